iir_first_order: RTL and testbench



---
 rtl/iir_first_order.sv | 76 +++++++
 tb/tb_iir_first_order.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/iir_first_order.sv
// First-order recursive filter y(n) = sat(COEF_A*y(n-1) + COEF_B*x(n)).
// The output register is also the feedback state; ovf latches any clamp until reset.
module iir_first_order #(
    parameter int XW     = 8,
    parameter int YW     = 17,
    parameter int COEF_A = -2,
    parameter int COEF_B = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [XW-1:0] x,
    output logic signed [YW-1:0] y,
    output logic                 ovf
);

    localparam int SW = YW + 5;

    // Clamp rails expressed in the wide sum domain so the comparison never wraps.
    localparam logic signed [SW-1:0] SUM_MAX = {{6{1'b0}}, {(YW-1){1'b1}}};
    localparam logic signed [SW-1:0] SUM_MIN = {{6{1'b1}}, {(YW-1){1'b0}}};

    localparam logic signed [3:0] COEF_A_4 = 4'(COEF_A);
    localparam logic signed [3:0] COEF_B_4 = 4'(COEF_B);

    logic signed [YW-1:0] y_reg;
    logic signed [YW-1:0] y_next;
    logic                 ovf_reg;
    logic                 ovf_next;

    logic signed [YW+3:0] coef_a_ext;
    logic signed [YW+3:0] y_ext;
    logic signed [YW+3:0] a_prod;
    logic signed [XW+3:0] coef_b_ext;
    logic signed [XW+3:0] x_ext;
    logic signed [XW+3:0] b_prod;
    logic signed [SW-1:0] sum;
    logic                 clamp_hi;
    logic                 clamp_lo;

    // Operands are widened to the product width first so the multiply is full precision.
    always_comb begin
        coef_a_ext = (YW+4)'(COEF_A_4);
        y_ext      = (YW+4)'(y_reg);
        a_prod     = coef_a_ext * y_ext;
        coef_b_ext = (XW+4)'(COEF_B_4);
        x_ext      = (XW+4)'(x);
        b_prod     = coef_b_ext * x_ext;
        sum        = SW'(a_prod) + SW'(b_prod);
    end

    always_comb begin
        clamp_hi = (sum > SUM_MAX);
        clamp_lo = (sum < SUM_MIN);
        y_next   = sum[YW-1:0];
        if (clamp_hi) begin
            y_next = SUM_MAX[YW-1:0];
        end else if (clamp_lo) begin
            y_next = SUM_MIN[YW-1:0];
        end
        ovf_next = ovf_reg | clamp_hi | clamp_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_reg   <= '0;
            ovf_reg <= 1'b0;
        end else begin
            y_reg   <= y_next;
            ovf_reg <= ovf_next;
        end
    end

    assign y   = y_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_iir_first_order.sv
// Directed-vector bench for iir_first_order: one record per clock edge, state carries across records.
module tb_iir_first_order;

    localparam int XW = 8;
    localparam int YW = 17;

    logic                 clk;
    logic                 rst_n;
    logic signed [XW-1:0] x;
    logic signed [YW-1:0] y;
    logic                 ovf;

    int checks;
    int errors;

    typedef struct {
        logic                 rst_n;
        logic signed [XW-1:0] x;
        logic signed [YW-1:0] exp_y;
        logic                 exp_ovf;
    } vec_t;

    vec_t vecs[$];

    iir_first_order #(
        .XW(XW),
        .YW(YW),
        .COEF_A(-2),
        .COEF_B(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .x(x),
        .y(y),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input int xv, input int yv, input logic o);
        vec_t v;
        v.rst_n   = r;
        v.x       = XW'(xv);
        v.exp_y   = YW'(yv);
        v.exp_ovf = o;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic r, input int xv,
                         input int exp_y, input logic exp_ovf);
        checks++;
        if (y !== YW'(exp_y)) begin
            errors++;
            $display("FAIL %s[%0d] y: got %0d, expected %0d (rst_n=%0b x=%0d)",
                     name, idx, y, exp_y, r, xv);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s[%0d] ovf: got %0b, expected %0b (rst_n=%0b x=%0d)",
                     name, idx, ovf, exp_ovf, r, xv);
        end
        $display("%s[%0d] rst_n=%0b x=%0d -> y=%0d ovf=%0b (expected y=%0d ovf=%0b)",
                 name, idx, r, xv, y, ovf, exp_y, exp_ovf);
    endtask

    initial begin
        int growth[17];
        int mid[6];
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        x      = '0;

        // Reset overrides x, then first sample after release
        add(0, 5, 0, 0);
        add(0, 5, 0, 0);
        add(1, 5, 15, 0);

        // Alternating input 1,2,... gives 3,0,...; then x=0 holds 0
        add(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) add(1, 1, 3, 0);
            else            add(1, 2, 0, 0);
        end
        for (int i = 0; i < 10; i++) add(1, 0, 0, 0);

        // Growth with x=1: y(n) = 1-(-2)^n, clamps at edge 17
        growth = '{3, -3, 9, -15, 33, -63, 129, -255, 513, -1023, 2049, -4095,
                   8193, -16383, 32769, -65535, 65535};
        add(0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(1, 1, growth[i], 0);
        add(1, 1, growth[16], 1);
        add(1, 1, -65536, 1);
        add(1, 1, 65535, 1);
        add(1, 1, -65536, 1);
        add(1, 0, 65535, 1);

        // Reset clears sticky ovf while saturated
        add(0, 127, 0, 0);
        add(1, 127, 381, 0);

        // Negative extreme input
        add(0, 0, 0, 0);
        add(1, -128, -384, 0);
        add(1, -128, 384, 0);
        add(1, -128, -1152, 0);

        // Mid-stream reset at y=-63, then restart
        mid = '{3, -3, 9, -15, 33, -63};
        add(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1, 1, mid[i], 0);
        add(0, 1, 0, 0);
        add(1, 1, 3, 0);
        add(1, 1, -3, 0);
        add(1, 1, 9, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            x     = vecs[i].x;
            @(posedge clk);
            #1;
            check("vec", i, vecs[i].rst_n, int'(vecs[i].x), int'(vecs[i].exp_y), vecs[i].exp_ovf);
        end

        // y must not follow x between edges: state is y=9, change x mid-cycle
        x = 8'sd100;
        #3;
        check("no_comb", 0, rst_n, 100, 9, 0);
        @(posedge clk);
        #1;
        // -2*9 + 3*100 = 282
        check("no_comb", 1, rst_n, 100, 282, 0);

        // Reset asserted for several edges while x is large keeps y and ovf at 0
        rst_n = 1'b0;
        x     = -8'sd128;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("hold_rst", i, rst_n, -128, 0, 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("hold_rst", 3, rst_n, -128, -384, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
